// File: rtl/fpu_pkg.sv
// Shared types and the fixed fadd vector table used by the fadd built-in self-test.
package fpu_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
    } fadd_vec_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        DONE
    } bist_state_e;

    localparam int unsigned FADD_NVEC = 5;

    localparam fadd_vec_t FADD_VECTORS [FADD_NVEC] = '{
        '{32'h40400000, 32'hC0400000, 32'h00000000},
        '{32'h00000000, 32'h00000000, 32'h00000000},
        '{32'h40400000, 32'hC37F0000, 32'hC37C0000},
        '{32'h40200000, 32'h40000000, 32'h40900000},
        '{32'h3F800000, 32'h3F800000, 32'h40000000}
    };

    // Constant-index lookup keeps the 8-bit run index free of array-width mismatches.
    function automatic fadd_vec_t fadd_vec_get(input logic [7:0] i);
        case (i)
            8'd0:    return FADD_VECTORS[0];
            8'd1:    return FADD_VECTORS[1];
            8'd2:    return FADD_VECTORS[2];
            8'd3:    return FADD_VECTORS[3];
            8'd4:    return FADD_VECTORS[4];
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fadd_bist.sv
// Built-in self-test sequencer for an external fadd: drives x1/x2 from the vector table,
// samples y LATENCY edges later and records bit-exact mismatches.
module fadd_bist
    import fpu_pkg::*;
#(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned NVEC    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] x1,
    output logic [31:0] x2,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_count,
    output logic [7:0]  fail_index,
    output logic [31:0] fail_y
);

    bist_state_e r_state;
    logic [7:0]  r_idx;
    logic [7:0]  r_cnt;

    fadd_vec_t   w_vec;
    logic        w_mismatch;
    logic        w_last;
    logic [7:0]  w_fail_cnt_inc;

    always_comb begin
        w_vec          = fadd_vec_get(r_idx);
        w_mismatch     = (y != w_vec.expected);
        w_last         = (r_idx == 8'(NVEC - 1));
        w_fail_cnt_inc = (fail_count == 8'hFF) ? fail_count : fail_count + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= 8'd0;
            r_cnt      <= 8'd0;
            x1         <= 32'd0;
            x2         <= 32'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= 8'd0;
            fail_index <= 8'hFF;
            fail_y     <= 32'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        fail_count <= 8'd0;
                        fail_index <= 8'hFF;
                        fail_y     <= 32'd0;
                        r_idx      <= 8'd0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    x1      <= w_vec.a;
                    x2      <= w_vec.b;
                    r_cnt   <= 8'(LATENCY);
                    r_state <= WAIT;
                end
                // A load of 0 or 1 both leave WAIT after a single cycle.
                WAIT: begin
                    if (r_cnt <= 8'd1) begin
                        r_cnt   <= 8'd0;
                        r_state <= CHECK;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                CHECK: begin
                    if (w_mismatch) begin
                        fail_count <= w_fail_cnt_inc;
                        if (fail_index == 8'hFF) begin
                            fail_index <= r_idx;
                            fail_y     <= y;
                        end
                    end
                    if (w_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= !w_mismatch && (fail_count == 8'd0);
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 8'd1;
                        r_state <= ISSUE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fadd_bist.sv
// Directed bench: fadd_bist with a registered fadd model (LATENCY=1) and a combinational one (LATENCY=0).
module tb_fadd_bist;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start0;
    logic [31:0] x1_1, x2_1, y1, x1_0, x2_0, y0;
    logic        busy1, done1, pass1, busy0, done0, pass0;
    logic [7:0]  fcnt1, fidx1, fcnt0, fidx0;
    logic [31:0] fy1, fy0;
    int          fault;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc;

    always #5 clk = ~clk;

    fadd_bist #(.LATENCY(1), .NVEC(5)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .x1(x1_1), .x2(x2_1), .y(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fcnt1), .fail_index(fidx1), .fail_y(fy1)
    );

    fadd_bist #(.LATENCY(0), .NVEC(5)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .x1(x1_0), .x2(x2_0), .y(y0),
        .busy(busy0), .done(done0), .pass(pass0),
        .fail_count(fcnt0), .fail_index(fidx0), .fail_y(fy0)
    );

    // Hand-written sums for the five table pairs; fault modes corrupt vector 3 or 0.
    function automatic logic [31:0] ref_fadd(input logic [31:0] a, input logic [31:0] b, input int f);
        logic [63:0] key;
        key = {a, b};
        if (f == 1 && key == 64'h40200000_40000000) return 32'h40900001;
        if (f == 2 && key == 64'h40400000_C0400000) return 32'h80000000;
        case (key)
            64'h40400000_C0400000: return 32'h00000000;
            64'h00000000_00000000: return 32'h00000000;
            64'h40400000_C37F0000: return 32'hC37C0000;
            64'h40200000_40000000: return 32'h40900000;
            64'h3F800000_3F800000: return 32'h40000000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    always @(posedge clk) y1 <= ref_fadd(x1_1, x2_1, fault);
    assign y0 = ref_fadd(x1_0, x2_0, 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // Pulse start on one DUT and count edges from the first ISSUE edge to done rising.
    task automatic run(input bit sel, input bit poke, output int n);
        @(negedge clk);
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        n = 0;
        chk("busy_after_start", sel ? busy0 : busy1, 1);
        while (!(sel ? done0 : done1) && n < 200) begin
            @(negedge clk);
            n++;
            if (poke && n == 2) start1 = 1'b1;
            if (poke && n == 3) start1 = 1'b0;
        end
        if (n >= 200) chk("done_timeout", 0, 1);
    endtask

    task automatic chk_results1(input string tag, input logic p, input logic [7:0] c,
                                input logic [7:0] i, input logic [31:0] fy);
        chk({tag, "_pass"}, pass1, p);
        chk({tag, "_fcnt"}, fcnt1, c);
        chk({tag, "_fidx"}, fidx1, i);
        chk({tag, "_fy"},   fy1,   fy);
        chk({tag, "_busy"}, busy1, 0);
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start0 = 1'b0; fault = 0;
        repeat (2) @(negedge clk);
        chk("rst_x1", x1_1, 0);
        chk("rst_x2", x2_1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_fcnt", fcnt1, 0);
        chk("rst_fidx", fidx1, 8'hFF);
        chk("rst_fy", fy1, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_hold_busy", busy1, 0);
        chk("idle_hold_done", done1, 0);

        // Clean run, LATENCY=1
        run(0, 0, cyc);
        chk("clean_cycles", 32'(cyc), 15);
        chk_results1("clean", 1, 0, 8'hFF, 0);
        chk("hold_x1", x1_1, 32'h3F800000);
        chk("hold_x2", x2_1, 32'h3F800000);

        // Vector 3 off by one ulp; restart from DONE discards the clean results
        fault = 1;
        run(0, 0, cyc);
        chk("ulp_cycles", 32'(cyc), 15);
        chk_results1("ulp", 0, 1, 3, 32'h40900001);

        // -0 on vector 0 must count as a mismatch
        fault = 2;
        run(0, 0, cyc);
        chk_results1("negzero", 0, 1, 0, 32'h80000000);

        // start during busy is ignored
        fault = 0;
        run(0, 1, cyc);
        chk("poke_cycles", 32'(cyc), 15);
        chk_results1("poke", 1, 0, 8'hFF, 0);

        // Reset during WAIT of vector 2
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (7) @(negedge clk);
        chk("wait2_x1", x1_1, 32'h40400000);
        chk("wait2_x2", x2_1, 32'hC37F0000);
        chk("wait2_busy", busy1, 1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy1, 0);
        chk("midrst_done", done1, 0);
        chk("midrst_x1", x1_1, 0);
        chk("midrst_fidx", fidx1, 8'hFF);
        @(negedge clk); rst = 1'b0;
        run(0, 0, cyc);
        chk("after_rst_cycles", 32'(cyc), 15);
        chk_results1("after_rst", 1, 0, 8'hFF, 0);

        // LATENCY=0 with combinational model, twice
        for (int k = 0; k < 2; k++) begin
            run(1, 0, cyc);
            chk($sformatf("lat0_cycles_%0d", k), 32'(cyc), 15);
            chk($sformatf("lat0_pass_%0d", k), pass0, 1);
            chk($sformatf("lat0_fcnt_%0d", k), fcnt0, 0);
            chk($sformatf("lat0_fidx_%0d", k), fidx0, 8'hFF);
            chk($sformatf("lat0_fy_%0d", k), fy0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fadd_bist.md
FADD_BIST -- requirements
Module: fadd_bist

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1, meaning the number of clk edges from fadd x1/x2 change to a valid y.
REQ-002 The block SHALL have parameter NVEC, default 5, meaning the number of vectors in the vector table.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  pulse; begins a run when the block is idle or done.
REQ-006 x1  output  32  operand A to fadd, IEEE-754 single.
REQ-007 x2  output  32  operand B to fadd, IEEE-754 single.
REQ-008 y  input  32  fadd result.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high from run completion until the next start or reset.
REQ-011 pass  output  1  valid with done; high iff every vector matched.
REQ-012 fail_count  output  8  number of mismatching vectors in the last run, saturating at 255.
REQ-013 fail_index  output  8  index of the first mismatching vector; 0xFF if there is none.
REQ-014 fail_y  output  32  y captured at the first mismatch; 0 if there is none.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT, CHECK, and DONE.
REQ-016 IDLE/DONE: start=1 SHALL clear fail_count, set fail_index=0xFF, clear fail_y, set idx=0, clear done, and go to ISSUE.
REQ-017 ISSUE (1 cycle) SHALL register x1/x2 from table[idx], load the wait counter with LATENCY, and go to WAIT.
REQ-018 WAIT SHALL decrement the counter each cycle and go to CHECK when the counter reaches 0, so y is sampled exactly LATENCY cycles after x1/x2 change.
REQ-019 CHECK SHALL compare y bit-exactly with table[idx].expected, with no tolerance and with +0 and -0 treated as distinct.
REQ-020 On a CHECK mismatch, fail_count SHALL increment (saturating at 255), and fail_index/fail_y SHALL load only if fail_index==0xFF.
REQ-021 CHECK with idx==NVEC-1 SHALL go to DONE; otherwise it SHALL increment idx and go to ISSUE.
REQ-022 One vector SHALL take LATENCY+2 cycles, and a full run SHALL take NVEC*(LATENCY+2) cycles from the first ISSUE to done rising.
REQ-023 busy SHALL be high in ISSUE, WAIT, and CHECK, and low in IDLE and DONE.
REQ-024 In DONE, pass SHALL equal (fail_count==0), and pass SHALL be 0 outside DONE.
REQ-025 start while busy SHALL be ignored, with no restart and no effect on results.
REQ-026 start in DONE SHALL restart the run, and the results of the previous run SHALL be discarded.
REQ-027 x1/x2 SHALL hold their last value in WAIT, CHECK, and DONE, so fadd inputs stay stable during sampling.
REQ-028 LATENCY=0 SHALL be legal: WAIT lasts one cycle (counter already 0) and the cycle count becomes NVEC*3.
REQ-029 The idx width SHALL be 8 bits, and NVEC SHALL be at most 255.

Reset
REQ-030 When rst is asserted at any time, including mid-run, the block SHALL immediately enter IDLE.
REQ-031 The reset values SHALL be x1=0, x2=0, busy=0, done=0, pass=0, fail_count=0, fail_index=0xFF, fail_y=0, idx=0, and wait counter=0.
REQ-032 After rst is released, the block SHALL stay in IDLE until start.

Structure
REQ-033 Package fpu_pkg SHALL hold the vector struct type {a, b, expected} (3x32 bits), the state enum, and the localparam table FADD_VECTORS[NVEC].
REQ-034 FADD_VECTORS SHALL be, in order:
- 0x40400000 + 0xC0400000 = 0x00000000
- 0x00000000 + 0x00000000 = 0x00000000
- 0x40400000 + 0xC37F0000 = 0xC37C0000
- 0x40200000 + 0x40000000 = 0x40900000
- 0x3F800000 + 0x3F800000 = 0x40000000
REQ-035 fadd_bist SHALL have no sub-module; fadd is instantiated beside it at the top level and wired x1/x2/y.

Verification
REQ-036 With a correct fadd, LATENCY=1, and start pulsed, done SHALL rise 15 cycles after ISSUE with pass=1, fail_count=0, and fail_index=0xFF.
REQ-037 With a fadd model forcing y=0x40900001 on vector 3, the result SHALL be pass=0, fail_count=1, fail_index=3, and fail_y=0x40900001.
REQ-038 With a model returning -0 (0x80000000) on vector 0, the result SHALL be fail_index=0, with the bit-exact mismatch counted.
REQ-039 Pulsing start at the third cycle of busy SHALL be ignored: done timing SHALL be unchanged and the results SHALL be identical.
REQ-040 Asserting rst during WAIT of vector 2 SHALL make busy=0, done=0, and x1=0 immediately; a following start SHALL produce a full clean run with pass=1.
REQ-041 With LATENCY=0, a combinational model, and a start pulse, done SHALL rise after 15 cycles with pass=1; a second start from DONE SHALL repeat the run identically.
